vcfg_ctrl: RTL and testbench
============================

VCFG_CTRL -- requirements
Module: vcfg_ctrl

Interface
REQ-001 SHALL have parameter VLEN, default 4096, meaning vector register length in bits (power of two, 128..RISCV_MAX_VLEN).
REQ-002 SHALL have parameter ELEN, default 64, meaning maximum supported element width in bits.
REQ-003 SHALL have clk_i, input, 1, the single clock.
REQ-004 SHALL have rst_ni, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have the request port: req_valid_i, input, 1; req_ready_o, output, 1; req_instr_i, input, 32, rvv_instruction_t (vsetvli, vsetivli or vsetvl); req_rs1_i, input, 64, AVL; req_rs2_i, input, 64, vsetvl vtype value.
REQ-006 SHALL have the response port: resp_valid_o, output, 1; resp_ready_i, input, 1; resp_rd_o, output, 64, new vl for rd.
REQ-007 SHALL have backend_idle_i, input, 1, high when no vector instruction is in flight.
REQ-008 SHALL have the CSR outputs: vtype_o, output, vtype_t; vl_o, output, 64; vstart_clr_o, output, 1, one-cycle vstart clear pulse; hist_tag_o, output, hist_tag_t, LUT history tag.

Function
REQ-009 SHALL use a state machine with states IDLE, CALC, DRAIN, COMMIT and RESP; req_ready_o SHALL be high only in IDLE.
REQ-010 SHALL, on req_valid_i && req_ready_o, register the instruction and operands and go to CALC.
REQ-011 SHALL decode the vtype bits as: [2:0] vlmul, [5:3] vsew, [6] vta, [7] vma, [10:8] vlut, [11] vreuse.
REQ-012 SHALL source those bits as follows: vsetvl from rs2[11:0]; vsetvli from zimm11 with vreuse=OFF; vsetivli from zimm10 with vlut[2]=0 and vreuse=OFF.
REQ-013 SHALL set vill for any of: vsew>EW64; vlmul==LMUL_RSVD; vlut>CB256; SEW>LMUL*ELEN; any vsetvl rs2 bit [63:12] nonzero.
REQ-014 SHALL compute VLMAX=(VLEN/SEW)*LMUL, where fractional LMUL divides.
REQ-015 SHALL take AVL as: uimm5 for vsetivli; rs1 value when rs1!=0; all-ones when rs1==0 and rd!=0.
REQ-016 SHALL keep the current vl when rs1==0 and rd==0, and SHALL set vill if the current vl>VLMAX.
REQ-017 SHALL set vl=min(AVL,VLMAX).
REQ-018 SHALL, when vill is set, commit vtype={vill=1, all other fields 0} and vl=0.
REQ-019 SHALL, in CALC, go to DRAIN if vsew, vlmul, vlut or vreuse differs from vtype_o and backend_idle_i=0; otherwise go to COMMIT.
REQ-020 SHALL hold in DRAIN until backend_idle_i=1, then go to COMMIT.
REQ-021 SHALL, in COMMIT, update vtype_o, vl_o and resp_rd_o (=new vl), pulse vstart_clr_o for one cycle, and go to RESP.
REQ-022 SHALL hold resp_valid_o high in RESP with resp_rd_o stable, and go to IDLE on resp_ready_i.
REQ-023 SHALL, with no drain, assert resp_valid_o 3 cycles after the accept edge.
REQ-024 SHALL not accept a new request in the cycle resp_ready_i is sampled; back-to-back requests are spaced by the FSM.

Reset
REQ-025 SHALL, on rst_ni low at any time, go to IDLE and set vtype_o={vill=1, all other fields 0}, vl_o=0, hist_tag_o=0, resp_valid_o=0, resp_rd_o=0 and vstart_clr_o=0.
REQ-026 SHALL drop an in-flight request on reset without producing a response.

Configuration
REQ-027 SHALL, with ARA_LUT_HIST_EN defined, increment hist_tag_o (mod 16, 15 wraps to 0) at each COMMIT with non-vill vtype, vreuse==VREUSE_OFF and vlut!=CBSEQ.
REQ-028 SHALL leave hist_tag_o unchanged at COMMIT otherwise.
REQ-029 SHALL, without ARA_LUT_HIST_EN, tie hist_tag_o to 0 and omit the counter.

Structure
REQ-030 SHALL place vcfg_state_e and the vtype bit-offset localparams in rvv_pkg.
REQ-031 SHALL implement the legality check and the VLMAX calculation in the combinational sub-module vcfg_vlmax_calc.

Verification (VLEN=4096)
REQ-032 SHALL cover: vsetvli rs1=x5, AVL=200, EW32, LMUL_1 -> vl_o=128, resp_rd_o=128, resp_valid_o 3 cycles after accept.
REQ-033 SHALL cover: vsetivli uimm5=17, EW8, LMUL_1_2 -> VLMAX=256, vl_o=17, vstart_clr_o pulses once.
REQ-034 SHALL cover: vsetvl with rs2 vsew=EW128, or rs2 bit 40 set -> vtype_o.vill=1, vl_o=0, resp_rd_o=0.
REQ-035 SHALL cover: vtype change with backend_idle_i=0 for 5 cycles -> FSM held in DRAIN, CSRs unchanged until 1 cycle after idle rises, response follows.
REQ-036 SHALL cover, with ARA_LUT_HIST_EN: 17 vsetvl with vreuse OFF and vlut CB16 -> hist_tag_o=1 (wrapped); one more with vreuse ON -> unchanged. Without the macro -> hist_tag_o=0 throughout.
REQ-037 SHALL cover: reset asserted in DRAIN -> IDLE, vill=1, no response, next request accepted normally.

Source files
------------

// File: rtl/rvv_pkg.sv
// Shared RVV configuration types: vtype layout, field encodings and vcfg FSM states.
// Used by vcfg_ctrl and vcfg_vlmax_calc.
package rvv_pkg;

   localparam int unsigned RISCV_MAX_VLEN = 65536;

   // Bit offsets of the fields inside the 12-bit architectural vtype value
   localparam int unsigned VtypeVlmulOff  = 0;
   localparam int unsigned VtypeVsewOff   = 3;
   localparam int unsigned VtypeVtaOff    = 6;
   localparam int unsigned VtypeVmaOff    = 7;
   localparam int unsigned VtypeVlutOff   = 8;
   localparam int unsigned VtypeVreuseOff = 11;

   typedef logic [31:0] rvv_instruction_t;
   typedef logic [3:0]  hist_tag_t;

   typedef enum logic [2:0] {
      EW8, EW16, EW32, EW64, EW128, EW256, EW512, EW1024
   } vew_e;

   typedef enum logic [2:0] {
      LMUL_1, LMUL_2, LMUL_4, LMUL_8, LMUL_RSVD, LMUL_1_8, LMUL_1_4, LMUL_1_2
   } vlmul_e;

   typedef enum logic [2:0] {
      CBSEQ, CB16, CB32, CB64, CB128, CB256, CB_RSVD6, CB_RSVD7
   } vlut_e;

   typedef enum logic {
      VREUSE_OFF, VREUSE_ON
   } vreuse_e;

   typedef struct packed {
      logic    vill;
      vreuse_e vreuse;
      vlut_e   vlut;
      logic    vma;
      logic    vta;
      vew_e    vsew;
      vlmul_e  vlmul;
   } vtype_t;

   typedef enum logic [2:0] {
      StIdle, StCalc, StDrain, StCommit, StResp
   } vcfg_state_e;

   localparam vtype_t VtypeIll = '{
      vill: 1'b1, vreuse: VREUSE_OFF, vlut: CBSEQ, vma: 1'b0, vta: 1'b0,
      vsew: EW8, vlmul: LMUL_1
   };

endpackage

// File: rtl/vcfg_vlmax_calc.sv
// Combinational vtype legality check and VLMAX = (VLEN/SEW)*LMUL, done in the log2 domain.
module vcfg_vlmax_calc
   import rvv_pkg::*;
#(
   parameter int unsigned VLEN = 4096,
   parameter int unsigned ELEN = 64
) (
   input  logic [11:0] vtype_raw_i,
   input  logic        rs2_hi_nz_i,
   output logic        vill_o,
   output logic [63:0] vlmax_o
);

   localparam int VlenLog2 = $clog2(VLEN);
   localparam int ElenLog2 = $clog2(ELEN);

   logic [2:0] vlmul, vsew, vlut;
   int         sew_l2, lmul_l2, vlmax_l2;

   assign vlmul = vtype_raw_i[VtypeVlmulOff +: 3];
   assign vsew  = vtype_raw_i[VtypeVsewOff +: 3];
   assign vlut  = vtype_raw_i[VtypeVlutOff +: 3];

   always_comb begin
      sew_l2   = 3 + int'(vsew);
      // Fractional encodings 5..7 map to log2 LMUL of -3..-1
      lmul_l2  = vlmul[2] ? int'(vlmul) - 8 : int'(vlmul);
      vlmax_l2 = VlenLog2 - sew_l2 + lmul_l2;
      vill_o   = rs2_hi_nz_i
                 || (vsew > EW64)
                 || (vlmul == LMUL_RSVD)
                 || (vlut > CB256)
                 || (sew_l2 > lmul_l2 + ElenLog2);
      vlmax_o  = '0;
      if (!vill_o && (vlmax_l2 >= 0) && (vlmax_l2 < 64)) begin
         vlmax_o = 64'd1 << vlmax_l2;
      end
   end

endmodule

// File: rtl/vcfg_ctrl.sv
// Vector configuration controller: executes vsetvli/vsetivli/vsetvl and owns vtype/vl.
// Optional LUT history tag counter enabled by defining ARA_LUT_HIST_EN.
module vcfg_ctrl
   import rvv_pkg::*;
#(
   parameter int unsigned VLEN = 4096,
   parameter int unsigned ELEN = 64
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  rvv_instruction_t req_instr_i,
   input  logic [63:0]      req_rs1_i,
   input  logic [63:0]      req_rs2_i,
   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic [63:0]      resp_rd_o,
   input  logic             backend_idle_i,
   output vtype_t           vtype_o,
   output logic [63:0]      vl_o,
   output logic             vstart_clr_o,
   output hist_tag_t        hist_tag_o
);

   vcfg_state_e      state_q, state_d;
   rvv_instruction_t instr_q, instr_d;
   logic [63:0]      rs1_q, rs1_d, rs2_q, rs2_d;
   vtype_t           vtype_q, vtype_d;
   logic [63:0]      vl_q, vl_d, rd_q, rd_d;

   logic        is_ivli, is_vl, keep_vl, rs2_hi_nz, calc_vill, vill, cfg_change;
   logic [4:0]  rs1_idx, rd_idx;
   logic [11:0] vtype_raw;
   logic [63:0] vlmax, avl, new_vl;
   vtype_t      new_vtype;

   // Opcode/funct3 are decoded upstream
   logic unused_instr;
   assign unused_instr = ^{instr_q[14:12], instr_q[6:0]};

   assign is_ivli   = instr_q[31] & instr_q[30];
   assign is_vl     = instr_q[31] & ~instr_q[30];
   assign rs1_idx   = instr_q[19:15];
   assign rd_idx    = instr_q[11:7];
   assign rs2_hi_nz = is_vl & (|rs2_q[63:12]);

   always_comb begin
      if (is_vl) begin
         vtype_raw = rs2_q[11:0];
      end else if (is_ivli) begin
         vtype_raw = {2'b00, instr_q[29:20]};
      end else begin
         vtype_raw = {1'b0, instr_q[30:20]};
      end
   end

   vcfg_vlmax_calc #(
      .VLEN (VLEN),
      .ELEN (ELEN)
   ) u_vlmax_calc (
      .vtype_raw_i (vtype_raw),
      .rs2_hi_nz_i (rs2_hi_nz),
      .vill_o      (calc_vill),
      .vlmax_o     (vlmax)
   );

   always_comb begin
      keep_vl = ~is_ivli & (rs1_idx == 5'd0) & (rd_idx == 5'd0);
      if (is_ivli) begin
         avl = {59'd0, rs1_idx};
      end else if (rs1_idx != 5'd0) begin
         avl = rs1_q;
      end else begin
         avl = '1;
      end
      vill = calc_vill | (keep_vl & (vl_q > vlmax));
      if (vill) begin
         new_vl    = '0;
         new_vtype = VtypeIll;
      end else begin
         new_vl    = keep_vl ? vl_q : ((avl < vlmax) ? avl : vlmax);
         new_vtype = vtype_t'({1'b0, vtype_raw});
      end
      // vta/vma changes do not need the backend drained
      cfg_change = (new_vtype.vsew != vtype_q.vsew) || (new_vtype.vlmul != vtype_q.vlmul)
                   || (new_vtype.vlut != vtype_q.vlut) || (new_vtype.vreuse != vtype_q.vreuse);
   end

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      vtype_d = vtype_q;
      vl_d    = vl_q;
      rd_d    = rd_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid_i) begin
               instr_d = req_instr_i;
               rs1_d   = req_rs1_i;
               rs2_d   = req_rs2_i;
               state_d = StCalc;
            end
         end
         StCalc:   state_d = (cfg_change && !backend_idle_i) ? StDrain : StCommit;
         StDrain:  if (backend_idle_i) state_d = StCommit;
         StCommit: begin
            vtype_d = new_vtype;
            vl_d    = new_vl;
            rd_d    = new_vl;
            state_d = StResp;
         end
         StResp:   if (resp_ready_i) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         instr_q <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         vtype_q <= VtypeIll;
         vl_q    <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         vtype_q <= vtype_d;
         vl_q    <= vl_d;
         rd_q    <= rd_d;
      end
   end

   assign req_ready_o  = (state_q == StIdle);
   assign resp_valid_o = (state_q == StResp);
   assign vstart_clr_o = (state_q == StCommit);
   assign vtype_o      = vtype_q;
   assign vl_o         = vl_q;
   assign resp_rd_o    = rd_q;

`ifdef ARA_LUT_HIST_EN
   hist_tag_t hist_q, hist_d;

   always_comb begin
      hist_d = hist_q;
      if ((state_q == StCommit) && !new_vtype.vill && (new_vtype.vreuse == VREUSE_OFF)
          && (new_vtype.vlut != CBSEQ)) begin
         hist_d = hist_q + 4'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hist_q <= '0;
      end else begin
         hist_q <= hist_d;
      end
   end

   assign hist_tag_o = hist_q;
`else
   assign hist_tag_o = '0;
`endif

endmodule

// File: tb/tb_vcfg_ctrl.sv
// Self-checking bench for vcfg_ctrl: spec-level arithmetic model plus per-cycle compare.
module tb_vcfg_ctrl;

   localparam int unsigned VLEN = 4096;
   localparam int unsigned ELEN = 64;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready_o;
   logic [31:0] req_instr = '0;
   logic [63:0] req_rs1 = '0, req_rs2 = '0;
   logic        resp_valid_o;
   logic        resp_ready = 1'b0;
   logic [63:0] resp_rd_o;
   logic        backend_idle = 1'b1;
   logic [12:0] dut_vtype;
   logic [63:0] vl_o;
   logic        vstart_clr_o;
   logic [3:0]  hist_tag_o;

   int checks = 0;
   int failures = 0;

   // Committed-CSR model and the result expected from the outstanding request
   logic [12:0] m_vtype = 13'h1000;
   logic [63:0] m_vl = '0;
   logic [3:0]  m_hist = '0;
   logic [12:0] pend_vtype;
   logic [63:0] pend_vl;
   logic [3:0]  pend_hist;
   logic        pend_valid = 1'b0;
   logic        prev_valid = 1'b0, prev_clr = 1'b0;
   int          clr_count = 0;
   int          last_lat = 0;

   always #5 clk = ~clk;

   vcfg_ctrl #(
      .VLEN (VLEN),
      .ELEN (ELEN)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready_o),
      .req_instr_i    (req_instr),
      .req_rs1_i      (req_rs1),
      .req_rs2_i      (req_rs2),
      .resp_valid_o   (resp_valid_o),
      .resp_ready_i   (resp_ready),
      .resp_rd_o      (resp_rd_o),
      .backend_idle_i (backend_idle),
      .vtype_o        (dut_vtype),
      .vl_o           (vl_o),
      .vstart_clr_o   (vstart_clr_o),
      .hist_tag_o     (hist_tag_o)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mk_vsetvli(input logic [10:0] zimm, input logic [4:0] rs1,
                                              input logic [4:0] rd);
      return {1'b0, zimm, rs1, 3'b111, rd, 7'b1010111};
   endfunction

   function automatic logic [31:0] mk_vsetivli(input logic [9:0] zimm, input logic [4:0] uimm,
                                               input logic [4:0] rd);
      return {2'b11, zimm, uimm, 3'b111, rd, 7'b1010111};
   endfunction

   function automatic logic [31:0] mk_vsetvl(input logic [4:0] rs1, input logic [4:0] rd);
      return {7'b1000000, 5'd2, rs1, 3'b111, rd, 7'b1010111};
   endfunction

   // Architectural result from SEW/LMUL arithmetic (LMUL as a fraction num/den)
   task automatic model_calc(input logic [31:0] ins, input logic [63:0] rs1v, input logic [63:0] rs2v,
                             input logic [63:0] cur_vl, output logic [12:0] vt,
                             output logic [63:0] vl);
      logic [11:0] raw;
      logic        ill, ivli, keep;
      int unsigned sew, num, den;
      logic [63:0] vlmax, avl;
      ivli = (ins[31:30] == 2'b11);
      ill  = 1'b0;
      if (!ins[31]) raw = {1'b0, ins[30:20]};
      else if (ivli) raw = {2'b00, ins[29:20]};
      else begin
         raw = rs2v[11:0];
         ill = (rs2v[63:12] != '0);
      end
      num = 1;
      den = 1;
      case (raw[2:0])
         3'd1: num = 2;
         3'd2: num = 4;
         3'd3: num = 8;
         3'd4: ill = 1'b1;
         3'd5: den = 8;
         3'd6: den = 4;
         3'd7: den = 2;
         default: num = 1;
      endcase
      if (raw[5:3] > 3'd3 || raw[10:8] > 3'd5) ill = 1'b1;
      sew = 8 * (1 << raw[5:3]);
      if (sew * den > ELEN * num) ill = 1'b1;
      vlmax = 64'((VLEN / sew) * num / den);
      keep = !ivli && (ins[19:15] == 5'd0) && (ins[11:7] == 5'd0);
      if (ivli) avl = {59'd0, ins[19:15]};
      else if (ins[19:15] != 5'd0) avl = rs1v;
      else avl = '1;
      if (keep && cur_vl > vlmax) ill = 1'b1;
      vl = keep ? cur_vl : ((avl < vlmax) ? avl : vlmax);
      vt = {1'b0, raw};
      if (ill) begin
         vt = 13'h1000;
         vl = '0;
      end
   endtask

   // Per-cycle compare against the model
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_ni) begin
            m_vtype    = 13'h1000;
            m_vl       = '0;
            m_hist     = '0;
            pend_valid = 1'b0;
            prev_valid = 1'b0;
            prev_clr   = 1'b0;
            check("rst_vtype", 64'(dut_vtype), 64'h1000);
            check("rst_vl", vl_o, 64'd0);
            check("rst_rd", resp_rd_o, 64'd0);
            check("rst_resp_valid", 64'(resp_valid_o), 64'd0);
            check("rst_vstart_clr", 64'(vstart_clr_o), 64'd0);
            check("rst_hist", 64'(hist_tag_o), 64'd0);
         end else begin
            if (resp_valid_o && !prev_valid) begin
               check("resp_expected", 64'(pend_valid), 64'd1);
               if (pend_valid) begin
                  m_vtype    = pend_vtype;
                  m_vl       = pend_vl;
                  m_hist     = pend_hist;
                  pend_valid = 1'b0;
               end
            end
            check("vstart_pulse", 64'(resp_valid_o && !prev_valid), 64'(prev_clr));
            check("vtype", 64'(dut_vtype), 64'(m_vtype));
            check("vl", vl_o, m_vl);
            check("hist", 64'(hist_tag_o), 64'(m_hist));
            if (resp_valid_o) check("resp_rd", resp_rd_o, m_vl);
            if (vstart_clr_o) clr_count++;
            prev_valid = resp_valid_o;
            prev_clr   = vstart_clr_o;
         end
      end
   end

   task automatic do_req(input logic [31:0] ins, input logic [63:0] rs1v, input logic [63:0] rs2v,
                         input int idle_low);
      logic [12:0] evt;
      logic [63:0] evl;
      logic [3:0]  eh;
      logic        differ;
      int          exp_lat, lat;
      @(negedge clk);
      model_calc(ins, rs1v, rs2v, m_vl, evt, evl);
      eh = m_hist;
`ifdef ARA_LUT_HIST_EN
      if (!evt[12] && !evt[11] && evt[10:8] != 3'd0) eh = m_hist + 4'd1;
`endif
      differ     = (evt[11:8] != m_vtype[11:8]) || (evt[5:0] != m_vtype[5:0]);
      exp_lat    = differ ? 3 + idle_low : 3;
      pend_vtype = evt;
      pend_vl    = evl;
      pend_hist  = eh;
      pend_valid = 1'b1;
      req_instr  = ins;
      req_rs1    = rs1v;
      req_rs2    = rs2v;
      req_valid  = 1'b1;
      backend_idle = (idle_low == 0);
      check("req_ready_idle", 64'(req_ready_o), 64'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 1;
      check("req_ready_busy", 64'(req_ready_o), 64'd0);
      while (!resp_valid_o && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat - 1 >= idle_low) backend_idle = 1'b1;
      end
      backend_idle = 1'b1;
      check("resp_latency", 64'(lat), 64'(exp_lat));
      last_lat = lat;
      @(posedge clk);
      #1;
      check("resp_hold", 64'(resp_valid_o), 64'd1);
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      check("resp_release", 64'(resp_valid_o), 64'd0);
      check("req_ready_after", 64'(req_ready_o), 64'd1);
   endtask

   initial begin
      int   clr_before;
      logic [3:0] hist_exp;
      repeat (3) @(negedge clk);
      #2 rst_ni = 1'b1;

      // vsetvli e32 m1, AVL 200
      do_req(mk_vsetvli(11'h010, 5'd5, 5'd10), 64'd200, 64'd0, 0);
      check("t1_vl", vl_o, 64'd128);
      check("t1_rd", resp_rd_o, 64'd128);
      check("t1_latency", 64'(last_lat), 64'd3);

      // vsetivli e8 mf2, uimm 17
      clr_before = clr_count;
      do_req(mk_vsetivli(10'h007, 5'd17, 5'd1), 64'd0, 64'd0, 0);
      check("t2_vl", vl_o, 64'd17);
      check("t2_vtype", 64'(dut_vtype), 64'h007);
      check("t2_clr_once", 64'(clr_count - clr_before), 64'd1);

      // Illegal vsetvl: EW128, then a high rs2 bit
      do_req(mk_vsetvl(5'd3, 5'd4), 64'd10, 64'h20, 0);
      check("t3_vill", 64'(dut_vtype), 64'h1000);
      check("t3_vl", vl_o, 64'd0);
      check("t3_rd", resp_rd_o, 64'd0);
      do_req(mk_vsetvl(5'd3, 5'd4), 64'd10, (64'd1 << 40) | 64'h10, 0);
      check("t4_vill", 64'(dut_vtype), 64'h1000);

      // rs1=x0 rd!=0 -> VLMAX; rs1=rd=x0 keeps vl (illegal when too large)
      do_req(mk_vsetvli(11'h01B, 5'd0, 5'd5), 64'd7, 64'd0, 0);
      check("t5_vlmax", vl_o, 64'd512);
      do_req(mk_vsetvli(11'h018, 5'd0, 5'd0), 64'd7, 64'd0, 0);
      check("t6_keep_vill", 64'(dut_vtype), 64'h1000);
      do_req(mk_vsetvli(11'h000, 5'd2, 5'd6), 64'd20, 64'd0, 0);
      do_req(mk_vsetvli(11'h008, 5'd0, 5'd0), 64'd99, 64'd0, 0);
      check("t8_keep_vl", vl_o, 64'd20);

      // Fractional LMUL too small for SEW, reserved vlut, legal vsetvl
      do_req(mk_vsetvli(11'h01F, 5'd2, 5'd6), 64'd4, 64'd0, 0);
      do_req(mk_vsetvl(5'd1, 5'd2), 64'd5, 64'h610, 0);
      do_req(mk_vsetvl(5'd1, 5'd2), 64'd1000, 64'h51, 0);
      check("t11_vl", vl_o, 64'd256);

      // vtype change with busy backend for 5 cycles, then a vma-only change
      do_req(mk_vsetvli(11'h00A, 5'd3, 5'd6), 64'd50, 64'd0, 5);
      check("t12_drain_latency", 64'(last_lat), 64'd8);
      check("t12_vl", vl_o, 64'd50);
      do_req(mk_vsetvli(11'h08A, 5'd3, 5'd6), 64'd50, 64'd0, 5);
      check("t13_no_drain_latency", 64'(last_lat), 64'd3);

      // Reset while held in DRAIN
      @(negedge clk);
      req_instr = mk_vsetvli(11'h000, 5'd3, 5'd6);
      req_rs1 = 64'd5;
      req_valid = 1'b1;
      backend_idle = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("t14_in_drain", 64'({req_ready_o, resp_valid_o}), 64'd0);
      rst_ni = 1'b0;
      #1;
      check("t14_async_vill", 64'(dut_vtype), 64'h1000);
      check("t14_async_ready", 64'(req_ready_o), 64'd1);
      repeat (2) @(negedge clk);
      #2 rst_ni = 1'b1;
      backend_idle = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("t14_no_resp", 64'(resp_valid_o), 64'd0);
      do_req(mk_vsetvli(11'h010, 5'd5, 5'd10), 64'd200, 64'd0, 0);
      check("t15_vl", vl_o, 64'd128);

      // History tag: 17 commits with vlut CB16, then one with vreuse on
      for (int i = 0; i < 17; i++) begin
         do_req(mk_vsetvl(5'd1, 5'd2), 64'd100, 64'h110, 0);
      end
`ifdef ARA_LUT_HIST_EN
      hist_exp = 4'd1;
`else
      hist_exp = 4'd0;
`endif
      check("t16_hist_wrap", 64'(hist_tag_o), 64'(hist_exp));
      check("t16_vl", vl_o, 64'd100);
      do_req(mk_vsetvl(5'd1, 5'd2), 64'd100, 64'h910, 0);
      check("t17_hist_reuse", 64'(hist_tag_o), 64'(hist_exp));

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
